// File: rtl/cache_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cache_ctrl_pkg
// Shared definitions for the cache refill controller: default widths and the
// controller state encoding.
// ---------------------------------------------------------------------------
package cache_ctrl_pkg;

    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_ADDR_WIDTH     = 32;
    localparam int DEF_PERF_CNT_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        MEM_READ  = 3'd2,
        MEM_WRITE = 3'd3,
        FILL      = 3'd4,
        RESPOND   = 3'd5
    } state_t;

    // True while a main-memory transaction is outstanding.
    function automatic logic is_mem_state(input state_t s);
        return (s == MEM_READ) || (s == MEM_WRITE);
    endfunction

endpackage

// File: rtl/cache_perf_counters.sv
// ---------------------------------------------------------------------------
// cache_perf_counters
// Three free-running event counters (hits, misses, memory stall cycles).
// All counters clear on reset and wrap modulo 2^CNT_WIDTH.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_hit_inc         count one lookup hit this cycle
//   i_miss_inc        count one lookup miss this cycle
//   i_stall_inc       count one memory stall cycle
//   o_hit_count       hit counter
//   o_miss_count      miss counter
//   o_stall_cycles    stall-cycle counter
// ---------------------------------------------------------------------------
module cache_perf_counters #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_hit_inc,
    input  logic                 i_miss_inc,
    input  logic                 i_stall_inc,
    output logic [CNT_WIDTH-1:0] o_hit_count,
    output logic [CNT_WIDTH-1:0] o_miss_count,
    output logic [CNT_WIDTH-1:0] o_stall_cycles
);

    logic [CNT_WIDTH-1:0] r_hit;
    logic [CNT_WIDTH-1:0] r_miss;
    logic [CNT_WIDTH-1:0] r_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit   <= '0;
            r_miss  <= '0;
            r_stall <= '0;
        end else begin
            if (i_hit_inc)   r_hit   <= r_hit + 1'b1;
            if (i_miss_inc)  r_miss  <= r_miss + 1'b1;
            if (i_stall_inc) r_stall <= r_stall + 1'b1;
        end
    end

    assign o_hit_count    = r_hit;
    assign o_miss_count   = r_miss;
    assign o_stall_cycles = r_stall;

endmodule

// File: rtl/cache_refill_controller.sv
// ---------------------------------------------------------------------------
// cache_refill_controller
// Sequences a two-way associative cache against main memory for one CPU
// load/store port: lookup, miss refill, and write-through with
// write-allocate. One request is in flight at a time.
//
// Optional feature macro: CACHE_PERF_COUNTERS_EN adds hit/miss/stall
// counter outputs; without it the ports and logic are absent and timing
// is unchanged.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_*_i / req_ready_o     CPU request handshake (accept in IDLE only)
//   resp_valid_o/resp_rdata_o one-cycle completion pulse, load data
//   cache_addr_o/cache_data_o address and fill data to the cache
//   cache_overwrite_o         cache write strobe (FILL state only)
//   cache_data_i/cache_hit_i  combinational cache lookup result
//   mem_req_o/mem_we_o        memory request (held until mem_ack_i)
//   mem_addr_o/mem_wdata_o    memory address / write data
//   mem_rdata_i/mem_ack_i     memory read data / completion
//   hit_count_o, miss_count_o, stall_cycles_o   (macro only) perf counters
// ---------------------------------------------------------------------------
module cache_refill_controller
    import cache_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int PERF_CNT_WIDTH = DEF_PERF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  req_ready_o,
    output logic                  resp_valid_o,
    output logic [DATA_WIDTH-1:0] resp_rdata_o,
    output logic [ADDR_WIDTH-1:0] cache_addr_o,
    output logic [DATA_WIDTH-1:0] cache_data_o,
    output logic                  cache_overwrite_o,
    input  logic [DATA_WIDTH-1:0] cache_data_i,
    input  logic                  cache_hit_i,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_ack_i
`ifdef CACHE_PERF_COUNTERS_EN
    ,
    output logic [PERF_CNT_WIDTH-1:0] hit_count_o,
    output logic [PERF_CNT_WIDTH-1:0] miss_count_o,
    output logic [PERF_CNT_WIDTH-1:0] stall_cycles_o
`endif
);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_we;
    logic [DATA_WIDTH-1:0] r_fill;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic w_mem_state;
    assign w_mem_state = is_mem_state(r_state);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_fill  <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid_i) begin
                        r_addr  <= req_addr_i;
                        r_wdata <= req_wdata_i;
                        r_we    <= req_we_i;
                        // Stores skip the lookup: write-through always goes
                        // to memory and then allocates in the cache.
                        r_state <= req_we_i ? MEM_WRITE : LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (cache_hit_i) begin
                        r_rdata <= cache_data_i;
                        r_state <= RESPOND;
                    end else begin
                        r_state <= MEM_READ;
                    end
                end
                MEM_READ, MEM_WRITE: begin
                    if (mem_ack_i) begin
                        // Both memory states end in the same fill; only the
                        // source of the fill word and the load-data update differ.
                        r_fill <= r_we ? r_wdata : mem_rdata_i;
                        if (!r_we) r_rdata <= mem_rdata_i;
                        r_state <= FILL;
                    end
                end
                FILL:    r_state <= RESPOND;
                RESPOND: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // All handshake outputs decode the registered state only.
    assign req_ready_o       = (r_state == IDLE);
    assign resp_valid_o      = (r_state == RESPOND);
    assign resp_rdata_o      = r_rdata;
    assign cache_addr_o      = r_addr;
    assign cache_data_o      = r_fill;
    assign cache_overwrite_o = (r_state == FILL);
    assign mem_req_o         = w_mem_state;
    assign mem_we_o          = (r_state == MEM_WRITE);
    assign mem_addr_o        = r_addr;
    assign mem_wdata_o       = r_wdata;

`ifdef CACHE_PERF_COUNTERS_EN
    logic w_hit_inc;
    logic w_miss_inc;
    logic w_stall_inc;

    assign w_hit_inc   = (r_state == LOOKUP) &&  cache_hit_i;
    assign w_miss_inc  = (r_state == LOOKUP) && !cache_hit_i;
    assign w_stall_inc = w_mem_state && !mem_ack_i;

    cache_perf_counters #(
        .CNT_WIDTH (PERF_CNT_WIDTH)
    ) u_perf (
        .clk            (clk),
        .rst            (rst),
        .i_hit_inc      (w_hit_inc),
        .i_miss_inc     (w_miss_inc),
        .i_stall_inc    (w_stall_inc),
        .o_hit_count    (hit_count_o),
        .o_miss_count   (miss_count_o),
        .o_stall_cycles (stall_cycles_o)
    );
`endif

endmodule
